nuc970_ecc_seq: RTL and testbench
=================================

NUC970_ECC_SEQ -- requirements
Module: nuc970_ecc_seq

Interface
REQ-001 Parameter BITS, default 8: decoder beat width in bits.
REQ-002 Parameter DATA_BITS, default 4288: data bits per sector.
REQ-003 Parameter T, default 4: correctable bits per sector.
REQ-004 Parameter ADDR_W, default 16: sector-buffer beat-address width.
REQ-005 Derived constant NBEATS SHALL be ceil(DATA_BITS/BITS), which is 536 at the defaults.
REQ-006 clk  in  1  sole clock; every register is updated on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cmd_valid  in  1  request to start a job.
REQ-009 cmd_nsect  in  4  number of sectors in the job.
REQ-010 cmd_ready  out  1  high only in IDLE.
REQ-011 rd_en  out  1  sector-buffer read strobe.
REQ-012 rd_addr  out  ADDR_W  buffer beat address.
REQ-013 rd_data  in  BITS  buffer read data, valid exactly 1 cycle after rd_en.
REQ-014 dec_start  out  1  marks the first beat of a sector to the decoder.
REQ-015 dec_data  out  BITS  data beat to the decoder.
REQ-016 dec_err  in  BITS  decoder error mask for the current beat.
REQ-017 dec_first  in  1  first error beat of a sector.
REQ-018 dec_valid  in  1  error beat is valid.
REQ-019 dec_last  in  1  last error beat of a sector.
REQ-020 dec_cnt  in  8  error count reported by the decoder.
REQ-021 corr_valid, corr_addr[ADDR_W], corr_mask[BITS]  out  correction write: XOR corr_mask into the buffer at corr_addr.
REQ-022 sts_valid  out  1  1-cycle pulse carrying a per-sector result.
REQ-023 sts_sect  out  4  sector index of the result.
REQ-024 sts_nerr  out  8  number of bits flipped in the sector.
REQ-025 sts_fail  out  1  the sector is uncorrectable.
REQ-026 done  out  1  1-cycle pulse at job end.

Function
REQ-027 The state machine SHALL have four states: IDLE, FEED, HOLD, DRAIN.
REQ-028 In IDLE, cmd_valid SHALL latch cmd_nsect and clear the sector counters; the next state is FEED, or DRAIN if cmd_nsect=0.
REQ-029 FEED SHALL assert rd_en for NBEATS consecutive cycles with rd_addr = sect*NBEATS + beat, with no gaps within a sector.
REQ-030 dec_data SHALL equal rd_data, and dec_start SHALL equal rd_en-of-beat-0 delayed 1 cycle, so dec_start coincides with beat 0 data.
REQ-031 At the end of a sector, the fed sector index SHALL be pushed into a 2-entry pending FIFO.
REQ-032 After that push, the next state SHALL be:
  - DRAIN if all sectors have been fed;
  - HOLD if the FIFO holds 2 entries;
  - otherwise FEED, with the next sector starting on the very next cycle.
REQ-033 HOLD SHALL return to FEED on the cycle after a FIFO pop.
REQ-034 DRAIN SHALL go to IDLE when the FIFO is empty and no result is in progress, pulsing done in the same cycle.
REQ-035 Error side: dec_first SHALL begin a result for the FIFO head sector and reset the beat index to 0; each dec_valid beat SHALL increment the beat index.
REQ-036 For each valid beat with dec_err != 0 and beat < NBEATS, the block SHALL output corr_valid=1, corr_addr = head*NBEATS + beat, corr_mask = dec_err.
REQ-037 Popcount(dec_err) SHALL be accumulated into an 8-bit sum that saturates at 255.
REQ-038 Any nonzero mask at beat >= NBEATS SHALL set the fail flag and SHALL NOT produce corr_valid.
REQ-039 On dec_last, the block SHALL pulse sts_valid on the next cycle with:
  - sts_sect = head;
  - sts_nerr = the accumulated sum;
  - sts_fail = (sum != dec_cnt) OR (dec_cnt > T) OR the out-of-range flag.
REQ-040 The FIFO SHALL be popped in the same cycle as that sts_valid pulse.
REQ-041 When sts_fail=1, corrections already issued for that sector SHALL stand; a status consumer handles the failure.
REQ-042 A FIFO push and pop in the same cycle SHALL keep the count unchanged.
REQ-043 A pop in the same cycle as an end-of-sector in FEED SHALL NOT cause an entry into HOLD.
REQ-044 dec_first while the FIFO is empty SHALL be ignored, along with the rest of that sector.
REQ-045 dec_first while a result is still open SHALL abort it with sts_fail=1 and then start a new result.
REQ-046 cmd_valid outside IDLE SHALL be ignored.
REQ-047 The address arithmetic (sect*NBEATS + beat) SHALL be computed at ADDR_W bits, truncating.

Reset
REQ-048 While reset is asserted, the block SHALL:
  - go to IDLE;
  - empty the FIFO and clear all counters;
  - drive cmd_ready=1;
  - drive all other outputs to 0.
REQ-049 Reset mid-job SHALL abandon the job. Late decoder outputs arriving after reset SHALL be ignored under REQ-044.

Verification
REQ-050 Scenario: nsect=1, clean data, dec_cnt=0. Required:
  - rd_addr sweeps 0..535;
  - exactly one dec_start;
  - no corr_valid;
  - sts {sect 0, nerr 0, fail 0};
  - then done.
REQ-051 Scenario: nsect=3, decoder slow to report. Required:
  - FEED stalls in HOLD after sector 1;
  - sector 2 begins the cycle after the sector 0 status;
  - results arrive in order 0, 1, 2.
REQ-052 Scenario: sector 1 with dec_err=8'h81 at beat 10 and 8'h04 at beat 535, dec_cnt=3. Required:
  - corr_addr values 546 and 1071;
  - sts {nerr 3, fail 0}.
REQ-053 Scenario: dec_cnt=5 with T=4, or popcount 2 against dec_cnt 3. Required: sts_fail=1 in both cases.
REQ-054 Scenario: reset asserted during FEED of sector 2, followed by a stray dec_first. Required:
  - the block is in IDLE with cmd_ready=1;
  - no sts_valid and no corr_valid are produced.
REQ-055 Scenario: cmd_nsect=0. Required: done pulses within 2 cycles and rd_en is never asserted.

Source files
------------

// File: rtl/nuc970_ecc_seq.sv
`default_nettype none
// ============================================================================
// nuc970_ecc_seq : sector-buffer feed and BCH decoder result sequencer
// Revision 1.0
// ============================================================================

module nuc970_ecc_seq #(
  parameter int BITS      = 8,
  parameter int DATA_BITS = 4288,
  parameter int T         = 4,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd_nsect,
  output logic              cmd_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BITS-1:0]   rd_data,
  output logic              dec_start,
  output logic [BITS-1:0]   dec_data,
  input  logic [BITS-1:0]   dec_err,
  input  logic              dec_first,
  input  logic              dec_valid,
  input  logic              dec_last,
  input  logic [7:0]        dec_cnt,
  output logic              corr_valid,
  output logic [ADDR_W-1:0] corr_addr,
  output logic [BITS-1:0]   corr_mask,
  output logic              sts_valid,
  output logic [3:0]        sts_sect,
  output logic [7:0]        sts_nerr,
  output logic              sts_fail,
  output logic              done
);

  localparam int NBEATS = (DATA_BITS + BITS - 1) / BITS;
  localparam int FBW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int EBW    = $clog2(NBEATS + 1) + 1;
  localparam int PCW    = $clog2(BITS + 1);
  localparam int SW     = PCW + 9;

  localparam logic [ADDR_W-1:0] NBEATS_A   = ADDR_W'(NBEATS);
  localparam logic [FBW-1:0]    LAST_FBEAT = FBW'(NBEATS - 1);
  localparam logic [EBW-1:0]    NBEATS_E   = EBW'(NBEATS);
  localparam logic [7:0]        T_8        = 8'(T);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nx;

  // Feed side
  logic [3:0]     nsect;
  logic [3:0]     sect;
  logic [FBW-1:0] fbeat;
  logic           start_q;

  // Pending-sector FIFO (fed but not yet reported)
  logic [3:0]     fifo_mem [0:1];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     fifo_cnt;
  logic [1:0]     cnt_after;

  // Result side
  logic           res_open;
  logic [3:0]     res_sect;
  logic [7:0]     err_sum;
  logic           oor;
  logic [EBW-1:0] ebeat;
  logic           sts_v_q;
  logic [3:0]     sts_sect_q;
  logic [7:0]     sts_nerr_q;
  logic           sts_fail_q;

  logic           feeding;
  logic           sect_end;
  logic           last_sect;
  logic           push;
  logic           pop;
  logic           drain_ok;
  logic [ADDR_W-1:0] feed_addr;

  assign feeding   = (state == FEED);
  assign sect_end  = feeding && (fbeat == LAST_FBEAT);
  assign last_sect = ({1'b0, sect} + 5'd1) == {1'b0, nsect};
  assign push      = sect_end;
  assign pop       = sts_v_q;
  assign cnt_after = fifo_cnt + {1'b0, push} - {1'b0, pop};
  assign drain_ok  = (fifo_cnt == 2'd0) && !res_open;
  assign feed_addr = ADDR_W'(sect) * NBEATS_A + ADDR_W'(fbeat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = (cmd_nsect == 4'd0) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (sect_end) begin
          if (last_sect) begin
            state_nx = DRAIN;
          end else if (cnt_after == 2'd2) begin
            state_nx = HOLD;
          end else begin
            state_nx = FEED;
          end
        end
      end
      HOLD: begin
        if (pop) begin
          state_nx = FEED;
        end
      end
      DRAIN: begin
        if (drain_ok) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nsect       <= '0;
      sect        <= '0;
      fbeat       <= '0;
      start_q     <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      start_q  <= feeding && (fbeat == '0);
      fifo_cnt <= cnt_after;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= sect;
        wr_ptr           <= ~wr_ptr;
      end
      if (state == IDLE && cmd_valid) begin
        nsect <= cmd_nsect;
        sect  <= '0;
        fbeat <= '0;
      end else if (feeding) begin
        if (sect_end) begin
          fbeat <= '0;
          sect  <= sect + 4'd1;
        end else begin
          fbeat <= fbeat + 1'b1;
        end
      end
    end
  end

  logic [PCW-1:0]    pcnt;
  logic              open_nx;
  logic [3:0]        sect_nx;
  logic [7:0]        sum_nx;
  logic              oor_nx;
  logic [EBW-1:0]    ebeat_nx;
  logic              emit;
  logic [3:0]        emit_sect;
  logic [7:0]        emit_nerr;
  logic              emit_fail;
  logic              fix;
  logic [ADDR_W-1:0] fix_addr;
  logic [1:0]        skip;
  logic [SW-1:0]     sum_w;

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < BITS; i++) begin
      pcnt = pcnt + PCW'(dec_err[i]);
    end
  end

  // A new result targets the oldest FIFO entry not already being retired this
  // cycle, either by the pending status pop or by the abort of an open result.
  always_comb begin
    open_nx   = res_open;
    sect_nx   = res_sect;
    sum_nx    = err_sum;
    oor_nx    = oor;
    ebeat_nx  = ebeat;
    emit      = 1'b0;
    emit_sect = res_sect;
    emit_nerr = err_sum;
    emit_fail = 1'b0;
    fix       = 1'b0;
    fix_addr  = '0;
    sum_w     = '0;
    skip      = {1'b0, pop} + {1'b0, res_open};

    if (dec_first) begin
      if (res_open) begin
        emit      = 1'b1;
        emit_fail = 1'b1;
      end
      open_nx  = (fifo_cnt > skip);
      sect_nx  = fifo_mem[rd_ptr ^ skip[0]];
      sum_nx   = '0;
      oor_nx   = 1'b0;
      ebeat_nx = '0;
    end

    if (dec_valid && open_nx) begin
      if (dec_err != '0) begin
        if (ebeat_nx < NBEATS_E) begin
          fix      = 1'b1;
          fix_addr = ADDR_W'(sect_nx) * NBEATS_A + ADDR_W'(ebeat_nx);
        end else begin
          oor_nx = 1'b1;
        end
      end
      sum_w  = SW'(sum_nx) + SW'(pcnt);
      sum_nx = (sum_w > SW'(255)) ? 8'hFF : sum_w[7:0];
      if (ebeat_nx != '1) begin
        ebeat_nx = ebeat_nx + 1'b1;
      end
    end

    if (dec_last && open_nx && !emit) begin
      emit      = 1'b1;
      emit_sect = sect_nx;
      emit_nerr = sum_nx;
      emit_fail = (sum_nx != dec_cnt) || (dec_cnt > T_8) || oor_nx;
      open_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_open   <= 1'b0;
      res_sect   <= '0;
      err_sum    <= '0;
      oor        <= 1'b0;
      ebeat      <= '0;
      sts_v_q    <= 1'b0;
      sts_sect_q <= '0;
      sts_nerr_q <= '0;
      sts_fail_q <= 1'b0;
    end else begin
      res_open   <= open_nx;
      res_sect   <= sect_nx;
      err_sum    <= sum_nx;
      oor        <= oor_nx;
      ebeat      <= ebeat_nx;
      sts_v_q    <= emit;
      sts_sect_q <= emit ? emit_sect : 4'd0;
      sts_nerr_q <= emit ? emit_nerr : 8'd0;
      sts_fail_q <= emit && emit_fail;
    end
  end

  assign cmd_ready  = reset || (state == IDLE);
  assign rd_en      = !reset && feeding;
  assign rd_addr    = reset ? '0 : feed_addr;
  assign dec_start  = !reset && start_q;
  assign dec_data   = reset ? '0 : rd_data;
  assign corr_valid = !reset && fix;
  assign corr_addr  = reset ? '0 : fix_addr;
  assign corr_mask  = (!reset && fix) ? dec_err : '0;
  assign sts_valid  = !reset && sts_v_q;
  assign sts_sect   = reset ? '0 : sts_sect_q;
  assign sts_nerr   = reset ? '0 : sts_nerr_q;
  assign sts_fail   = !reset && sts_fail_q;
  assign done       = !reset && (state == DRAIN) && drain_ok;

endmodule

`default_nettype wire

// File: tb/tb_nuc970_ecc_seq.sv
`default_nettype none
// ============================================================================
// tb_nuc970_ecc_seq : self-checking bench with buffer and decoder models
// Revision 1.0
// ============================================================================

module tb_nuc970_ecc_seq;

  localparam int BITS      = 8;
  localparam int DATA_BITS = 4288;
  localparam int T         = 4;
  localparam int ADDR_W    = 16;
  localparam int NB        = (DATA_BITS + BITS - 1) / BITS;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [3:0]        cmd_nsect;
  logic              cmd_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [BITS-1:0]   rd_data;
  logic              dec_start;
  logic [BITS-1:0]   dec_data;
  logic [BITS-1:0]   dec_err;
  logic              dec_first;
  logic              dec_valid;
  logic              dec_last;
  logic [7:0]        dec_cnt;
  logic              corr_valid;
  logic [ADDR_W-1:0] corr_addr;
  logic [BITS-1:0]   corr_mask;
  logic              sts_valid;
  logic [3:0]        sts_sect;
  logic [7:0]        sts_nerr;
  logic              sts_fail;
  logic              done;

  always #5 clk = ~clk;

  nuc970_ecc_seq #(
    .BITS(BITS), .DATA_BITS(DATA_BITS), .T(T), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_nsect(cmd_nsect), .cmd_ready(cmd_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dec_start(dec_start), .dec_data(dec_data),
    .dec_err(dec_err), .dec_first(dec_first), .dec_valid(dec_valid),
    .dec_last(dec_last), .dec_cnt(dec_cnt),
    .corr_valid(corr_valid), .corr_addr(corr_addr), .corr_mask(corr_mask),
    .sts_valid(sts_valid), .sts_sect(sts_sect), .sts_nerr(sts_nerr),
    .sts_fail(sts_fail), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bufdata(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Buffer model: read data one cycle after the strobe
  logic        pend;
  logic [15:0] pa;
  initial begin
    rd_data = '0;
    forever begin
      @(negedge clk);
      pend = rd_en;
      pa   = rd_addr;
      @(posedge clk);
      #1;
      rd_data = pend ? bufdata(pa) : 8'h00;
    end
  end

  // Output monitor
  int cyc = 0, rd_cnt = 0, rd_bad = 0, ds_cnt = 0, ds_bad = 0, dd_bad = 0;
  int done_cnt = 0, done_cyc = 0, cmd_cyc = 0;
  logic [23:0] got_corr[$];
  logic [12:0] got_sts[$];
  int          sts_cyc[$];
  int          start_cyc[$];
  logic [23:0] exp_corr[$];
  logic [12:0] exp_sts[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && dec_data !== rd_data) dd_bad++;
      if (cmd_valid && cmd_ready) cmd_cyc = cyc;
      if (rd_en) begin
        if (rd_cnt % NB == 0) start_cyc.push_back(cyc);
        if (rd_addr !== 16'(rd_cnt)) rd_bad++;
        rd_cnt++;
      end
      if (dec_start) begin
        if (dec_data !== bufdata(16'(ds_cnt * NB))) ds_bad++;
        ds_cnt++;
      end
      if (corr_valid) got_corr.push_back({corr_addr, corr_mask});
      if (sts_valid) begin
        got_sts.push_back({sts_sect, sts_nerr, sts_fail});
        sts_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  logic [7:0] emask [0:NB+1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_cnt = 0; rd_bad = 0; ds_cnt = 0; ds_bad = 0; dd_bad = 0; done_cnt = 0;
    got_corr.delete(); got_sts.delete(); sts_cyc.delete(); start_cyc.delete();
    exp_corr.delete(); exp_sts.delete();
  endtask

  task automatic clear_emask();
    for (int b = 0; b < NB + 2; b++) emask[b] = 8'h00;
  endtask

  task automatic rand_emask(input int k);
    for (int i = 0; i < k; i++) emask[$urandom_range(0, NB - 1)] = 8'($urandom_range(1, 255));
  endtask

  function automatic int esum(input int nb);
    int s = 0;
    for (int b = 0; b < nb; b++) s += $countones(emask[b]);
    return (s > 255) ? 255 : s;
  endfunction

  // Reference: every in-range nonzero mask is one correction; status from bit totals
  task automatic expect_sector(input int s, input int nb, input int cnt);
    int  sum;
    bit  oorf;
    oorf = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (emask[b] != 8'h00) begin
        if (b < NB) exp_corr.push_back({16'(s * NB + b), emask[b]});
        else oorf = 1'b1;
      end
    end
    sum = esum(nb);
    exp_sts.push_back({4'(s), 8'(sum), (sum != cnt) || (cnt > T) || oorf});
  endtask

  task automatic decode(input int nb, input logic [7:0] cnt, input bit with_last);
    for (int b = 0; b < nb; b++) begin
      dec_valid = 1'b1;
      dec_first = (b == 0);
      dec_last  = with_last && (b == nb - 1);
      dec_err   = emask[b];
      dec_cnt   = cnt;
      tick();
    end
    dec_valid = 1'b0; dec_first = 1'b0; dec_last = 1'b0; dec_err = '0;
  endtask

  task automatic wait_rd(input int target, input int limit);
    int g = 0;
    while (rd_cnt < target && g < limit) begin
      tick();
      g++;
    end
    if (rd_cnt < target) check("wait_rd_timeout", rd_cnt, target);
  endtask

  task automatic wait_done(input int limit);
    int g = 0;
    while (done_cnt == 0 && g < limit) begin
      tick();
      g++;
    end
    if (done_cnt == 0) check("wait_done_timeout", done_cnt, 1);
    repeat (3) tick();
  endtask

  task automatic decode_sector(input int s, input int nb, input int cnt, input int dly);
    wait_rd((s + 1) * NB, 6000);
    repeat (dly) tick();
    expect_sector(s, nb, cnt);
    decode(nb, 8'(cnt), 1'b1);
  endtask

  task automatic start(input int n);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_nsect = 4'(n);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_job(input int n);
    check("rd_count", rd_cnt, n * NB);
    check("rd_addr_seq_errs", rd_bad, 0);
    check("dec_start_count", ds_cnt, n);
    check("dec_start_data_errs", ds_bad, 0);
    check("dec_data_errs", dd_bad, 0);
    check("done_count", done_cnt, 1);
    check("corr_count", got_corr.size(), exp_corr.size());
    for (int i = 0; i < got_corr.size() && i < exp_corr.size(); i++)
      check("corr_addr_mask", got_corr[i], exp_corr[i]);
    check("sts_count", got_sts.size(), exp_sts.size());
    for (int i = 0; i < got_sts.size() && i < exp_sts.size(); i++)
      check("sts_sect_nerr_fail", got_sts[i], exp_sts[i]);
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b1; cmd_valid = 1'b0; cmd_nsect = '0;
    dec_err = '0; dec_first = 1'b0; dec_valid = 1'b0; dec_last = 1'b0; dec_cnt = '0;
    clear_emask();
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_dec_start", dec_start, 0);
    check("rst_corr_valid", corr_valid, 0);
    check("rst_sts_valid", sts_valid, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // One clean sector
    clear_mon();
    start(1);
    clear_emask();
    decode_sector(0, NB, 0, 3);
    wait_done(3000);
    check_job(1);

    // Slow decoder: feed stalls after sector 1; sector 1 carries known errors
    clear_mon();
    start(3);
    wait_rd(2 * NB, 3000);
    repeat (30) tick();
    check("hold_stalled_rd_count", rd_cnt, 2 * NB);
    clear_emask();
    rand_emask(2);
    decode_sector(0, NB, esum(NB), 0);
    clear_emask();
    emask[10] = 8'h81;
    emask[535] = 8'h04;
    decode_sector(1, NB, 3, 0);
    clear_emask();
    decode_sector(2, NB, 0, 2);
    wait_done(4000);
    check_job(3);
    check("hold_sector_starts", start_cyc.size(), 3);
    if (start_cyc.size() == 3 && sts_cyc.size() > 0)
      check("sect2_start_after_sts0", start_cyc[2], sts_cyc[0] + 1);

    // Failure classes: over T, count mismatch, out-of-range beat, saturation
    clear_mon();
    start(4);
    clear_emask(); emask[3] = 8'h1F;
    decode_sector(0, NB, 5, 0);
    clear_emask(); emask[100] = 8'h03;
    decode_sector(1, NB, 3, 0);
    clear_emask(); emask[0] = 8'h01; emask[NB] = 8'h10;
    decode_sector(2, NB + 1, 2, 0);
    clear_emask();
    for (int b = 0; b < NB; b++) emask[b] = 8'hFF;
    decode_sector(3, NB, 255, 0);
    wait_done(4000);
    check_job(4);

    // Abort: a result left open is closed as failed by the next dec_first
    clear_mon();
    start(2);
    wait_rd(2 * NB, 3000);
    clear_emask(); emask[2] = 8'h01;
    exp_corr.push_back({16'd2, 8'h01});
    exp_sts.push_back({4'd0, 8'd1, 1'b1});
    decode(5, 8'd1, 1'b0);
    clear_emask();
    rand_emask(1);
    expect_sector(1, NB, esum(NB));
    decode(NB, 8'(esum(NB)), 1'b1);
    wait_done(3000);
    check_job(2);

    // Reset in the middle of sector 2, then a stray decoder result
    clear_mon();
    start(4);
    clear_emask();
    decode_sector(0, NB, 0, 0);
    wait_rd(2 * NB + 100, 3000);
    reset = 1'b1;
    tick();
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_rd_en", rd_en, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    clear_mon();
    clear_emask(); emask[1] = 8'hFF; emask[4] = 8'h01;
    decode(10, 8'd9, 1'b1);
    repeat (5) tick();
    check("stray_corr_count", got_corr.size(), 0);
    check("stray_sts_count", got_sts.size(), 0);
    check("stray_cmd_ready", cmd_ready, 1);
    check("stray_rd_count", rd_cnt, 0);
    check("stray_done_count", done_cnt, 0);

    // Empty job
    clear_mon();
    start(0);
    repeat (4) tick();
    check("nsect0_done_count", done_cnt, 1);
    check("nsect0_done_latency_le2", 32'((done_cyc - cmd_cyc) <= 2 && done_cyc > cmd_cyc), 1);
    check("nsect0_rd_count", rd_cnt, 0);

    // Randomized jobs with a stray command mid-job
    for (int j = 0; j < 3; j++) begin
      n = $urandom_range(1, 3);
      clear_mon();
      start(n);
      repeat (5) tick();
      cmd_valid = 1'b1;
      cmd_nsect = 4'($urandom_range(1, 15));
      tick();
      cmd_valid = 1'b0;
      for (int s = 0; s < n; s++) begin
        clear_emask();
        rand_emask($urandom_range(0, 3));
        cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : esum(NB);
        decode_sector(s, NB, cnt, $urandom_range(0, 40));
      end
      wait_done(4000);
      check_job(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
